reorder_buffer: RTL and testbench

REORDER_BUFFER -- requirements
Module: reorder_buffer

---
 rtl/reorder_buffer.sv | 181 ++++++++++++++++++
 tb/tb_reorder_buffer.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// -----------------------------------------------------------------------------
// reorder_buffer
//
// Circular in-order retirement buffer. Entries are allocated at the tail. Each
// entry receives its result through a tag-addressed writeback. Entries retire
// from the head in program order once their result is present. A flush
// squashes every entry younger than a given tag.
//
// Optional feature (compile-time macro):
//   ROB_WB_BYPASS_EN - a writeback that targets the not-yet-ready head makes
//                      that head committable in the same cycle, with the
//                      writeback data forwarded onto commit_value. When the
//                      macro is not defined, the entry becomes committable one
//                      cycle after its writeback.
//
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   alloc_valid/ready    allocation handshake; the entry is written at the tail
//   alloc_inst_type/preg/lreg   payload of the allocated entry
//   alloc_tag            tail index that the next allocation receives
//   wb_valid/tag/value   result writeback; ignored unless the tag is occupied
//   commit_valid/ready   retire handshake for the head entry
//   commit_tag/inst_type/preg/lreg/value   contents of the head entry
//   flush_valid/tag      squash every entry younger than flush_tag
//   count, empty, full   occupancy
// -----------------------------------------------------------------------------
module reorder_buffer #(
   parameter  int DEPTH      = 4,
   parameter  int DATA_WIDTH = 32,
   parameter  int PREG_BITS  = 6,
   localparam int TW         = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  alloc_valid,
   output logic                  alloc_ready,
   input  logic [1:0]            alloc_inst_type,
   input  logic [PREG_BITS-1:0]  alloc_preg,
   input  logic [4:0]            alloc_lreg,
   output logic [TW-1:0]         alloc_tag,
   input  logic                  wb_valid,
   input  logic [TW-1:0]         wb_tag,
   input  logic [DATA_WIDTH-1:0] wb_value,
   output logic                  commit_valid,
   input  logic                  commit_ready,
   output logic [TW-1:0]         commit_tag,
   output logic [1:0]            commit_inst_type,
   output logic [PREG_BITS-1:0]  commit_preg,
   output logic [4:0]            commit_lreg,
   output logic [DATA_WIDTH-1:0] commit_value,
   input  logic                  flush_valid,
   input  logic [TW-1:0]         flush_tag,
   output logic [TW:0]           count,
   output logic                  empty,
   output logic                  full
);

   localparam logic [TW:0] DEPTH_PTR = (TW+1)'(DEPTH);
   localparam logic [TW:0] ONE_PTR   = (TW+1)'(1);

   // The pointers carry one extra wrap bit, so full and empty can be told
   // apart when the head and tail indices are equal.
   logic [TW:0]           head_q, head_d;
   logic [TW:0]           tail_q, tail_d;
   logic [DEPTH-1:0]      ready_q, ready_d;
   logic [1:0]            itype_q [DEPTH];
   logic [1:0]            itype_d [DEPTH];
   logic [PREG_BITS-1:0]  preg_q  [DEPTH];
   logic [PREG_BITS-1:0]  preg_d  [DEPTH];
   logic [4:0]            lreg_q  [DEPTH];
   logic [4:0]            lreg_d  [DEPTH];
   logic [DATA_WIDTH-1:0] value_q [DEPTH];
   logic [DATA_WIDTH-1:0] value_d [DEPTH];

   logic [TW-1:0] head_idx;
   logic [TW-1:0] tail_idx;
   logic [TW-1:0] wb_off;
   logic [TW-1:0] flush_off;
   logic          wb_hit;
   logic          flush_hit;
   logic          alloc_fire;
   logic          commit_fire;
   logic          head_bypass;

   assign head_idx = head_q[TW-1:0];
   assign tail_idx = tail_q[TW-1:0];

   assign count = tail_q - head_q;
   assign empty = (count == '0);
   assign full  = (count == DEPTH_PTR);

   // Allocation looks only at the registered fullness. A retire in the same
   // cycle does not free a slot early, and a flush cycle never allocates.
   assign alloc_ready = !full && !flush_valid;
   assign alloc_tag   = tail_idx;
   assign alloc_fire  = alloc_valid && alloc_ready;

   // A tag is occupied when its distance from the head, modulo DEPTH, is
   // below the occupancy. This covers every wrap case, including a full buffer.
   assign wb_off    = wb_tag - head_idx;
   assign flush_off = flush_tag - head_idx;
   assign wb_hit    = wb_valid && ({1'b0, wb_off} < count);
   assign flush_hit = flush_valid && ({1'b0, flush_off} < count);

`ifdef ROB_WB_BYPASS_EN
   assign head_bypass = wb_hit && (wb_tag == head_idx) && !ready_q[head_idx];
`else
   assign head_bypass = 1'b0;
`endif

   assign commit_valid     = !empty && (ready_q[head_idx] || head_bypass);
   assign commit_fire      = commit_valid && commit_ready;
   assign commit_tag       = head_idx;
   assign commit_inst_type = itype_q[head_idx];
   assign commit_preg      = preg_q[head_idx];
   assign commit_lreg      = lreg_q[head_idx];
   assign commit_value     = head_bypass ? wb_value : value_q[head_idx];

   // Next-state logic. Writeback, allocation, flush and commit are each
   // evaluated against the registered head/tail, so events in the same cycle
   // combine without seeing each other. The flush target is measured from
   // the pre-commit head. A commit in the same cycle still advances the head,
   // and count then reflects both events. The commit clears the head ready bit
   // last, so an entry that retires on its bypassed writeback leaves no
   // stale ready bit behind.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      ready_d = ready_q;
      itype_d = itype_q;
      preg_d  = preg_q;
      lreg_d  = lreg_q;
      value_d = value_q;

      if (wb_hit) begin
         value_d[wb_tag] = wb_value;
         ready_d[wb_tag] = 1'b1;
      end

      if (alloc_fire) begin
         itype_d[tail_idx] = alloc_inst_type;
         preg_d[tail_idx]  = alloc_preg;
         lreg_d[tail_idx]  = alloc_lreg;
         ready_d[tail_idx] = 1'b0;
         tail_d            = tail_q + ONE_PTR;
      end

      if (flush_hit) begin
         tail_d = head_q + {1'b0, flush_off} + ONE_PTR;
      end

      if (commit_fire) begin
         ready_d[head_idx] = 1'b0;
         head_d            = head_q + ONE_PTR;
      end
   end

   // Control state: the pointers and ready bits. Reset discards every entry
   // and overrides any event in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         ready_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         ready_q <= ready_d;
      end
   end

   // Payload storage. It has no reset because a slot is only read after an
   // allocation has written it.
   always_ff @(posedge clk) begin
      itype_q <= itype_d;
      preg_q  <= preg_d;
      lreg_q  <= lreg_d;
      value_q <= value_d;
   end

endmodule

// File: tb/tb_reorder_buffer.sv
// -----------------------------------------------------------------------------
// tb_reorder_buffer
//
// Self-checking bench for reorder_buffer with DEPTH=4. Inputs change on the
// falling clock edge, and outputs are sampled 1ns later. A queue-based model
// of the in-flight instructions supplies the expected outputs during the
// randomized phase. The directed scenarios compare against fixed constants.
// -----------------------------------------------------------------------------
module tb_reorder_buffer;

   localparam int DEPTH = 4;
   localparam int DW    = 32;
   localparam int PB    = 6;
   localparam int TW    = 2;

`ifdef ROB_WB_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic          clk;
   logic          rst;
   logic          alloc_valid;
   logic          alloc_ready;
   logic [1:0]    alloc_inst_type;
   logic [PB-1:0] alloc_preg;
   logic [4:0]    alloc_lreg;
   logic [TW-1:0] alloc_tag;
   logic          wb_valid;
   logic [TW-1:0] wb_tag;
   logic [DW-1:0] wb_value;
   logic          commit_valid;
   logic          commit_ready;
   logic [TW-1:0] commit_tag;
   logic [1:0]    commit_inst_type;
   logic [PB-1:0] commit_preg;
   logic [4:0]    commit_lreg;
   logic [DW-1:0] commit_value;
   logic          flush_valid;
   logic [TW-1:0] flush_tag;
   logic [TW:0]   count;
   logic          empty;
   logic          full;

   int checks = 0;
   int errors = 0;

   reorder_buffer #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .PREG_BITS(PB)) dut (
      .clk(clk), .rst(rst),
      .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
      .alloc_inst_type(alloc_inst_type), .alloc_preg(alloc_preg),
      .alloc_lreg(alloc_lreg), .alloc_tag(alloc_tag),
      .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_value(wb_value),
      .commit_valid(commit_valid), .commit_ready(commit_ready),
      .commit_tag(commit_tag), .commit_inst_type(commit_inst_type),
      .commit_preg(commit_preg), .commit_lreg(commit_lreg),
      .commit_value(commit_value),
      .flush_valid(flush_valid), .flush_tag(flush_tag),
      .count(count), .empty(empty), .full(full)
   );

   // Free-running 10ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: in-flight instructions, oldest first, plus the tag of
   // the oldest one.
   typedef struct {
      logic [1:0]    itype;
      logic [PB-1:0] preg;
      logic [4:0]    lreg;
      logic [DW-1:0] value;
      bit            ready;
   } ent_t;

   ent_t mq[$];
   int   mhead = 0;

   function automatic int m_pos(int t);
      return (t - mhead + DEPTH) % DEPTH;
   endfunction

   function automatic bit m_occ(int t);
      return m_pos(t) < mq.size();
   endfunction

   function automatic bit m_bypass();
      return BYPASS && (mq.size() > 0) && wb_valid && (int'(wb_tag) == mhead) && !mq[0].ready;
   endfunction

   function automatic bit m_cv();
      return (mq.size() > 0) && (mq[0].ready || m_bypass());
   endfunction

   function automatic logic [DW-1:0] m_cval();
      return m_bypass() ? wb_value : mq[0].value;
   endfunction

   // Apply one clock's worth of events to the model, based on the inputs
   // that the DUT saw at the edge.
   task automatic model_step();
      bit   af;
      bit   cf;
      int   keep;
      ent_t e;
      if (rst) begin
         mq.delete();
         mhead = 0;
      end else begin
         af = alloc_valid && (mq.size() < DEPTH) && !flush_valid;
         cf = m_cv() && commit_ready;
         if (wb_valid && m_occ(int'(wb_tag))) begin
            e = mq[m_pos(int'(wb_tag))];
            e.value = wb_value;
            e.ready = 1'b1;
            mq[m_pos(int'(wb_tag))] = e;
         end
         if (flush_valid && m_occ(int'(flush_tag))) begin
            keep = m_pos(int'(flush_tag)) + 1;
            while (mq.size() > keep) void'(mq.pop_back());
         end
         if (af) begin
            e.itype = alloc_inst_type;
            e.preg  = alloc_preg;
            e.lreg  = alloc_lreg;
            e.value = '0;
            e.ready = 1'b0;
            mq.push_back(e);
         end
         if (cf) begin
            void'(mq.pop_front());
            mhead = (mhead + 1) % DEPTH;
         end
      end
   endtask

   // One clock: rising edge, model update, then back to the falling edge
   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic idle();
      alloc_valid  = 1'b0;
      wb_valid     = 1'b0;
      commit_ready = 1'b0;
      flush_valid  = 1'b0;
   endtask

   task automatic drive_alloc();
      alloc_valid     = 1'b1;
      alloc_inst_type = 2'($urandom_range(0, 3));
      alloc_preg      = PB'($urandom_range(0, 63));
      alloc_lreg      = 5'($urandom_range(0, 31));
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      idle();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      #1;
      checks++; if (count !== 3'd0) begin errors++; $display("[TB] FAIL reset_count got %0d want 0", count); end
      checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL reset_empty got %b want 1", empty); end
      checks++; if (full !== 1'b0) begin errors++; $display("[TB] FAIL reset_full got %b want 0", full); end
      checks++; if (alloc_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_alloc_ready got %b want 1", alloc_ready); end
      checks++; if (alloc_tag !== 2'd0) begin errors++; $display("[TB] FAIL reset_alloc_tag got %0d want 0", alloc_tag); end
      checks++; if (commit_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_commit_valid got %b want 0", commit_valid); end
   endtask

   task automatic test_fill();
      for (int i = 0; i < 4; i++) begin
         drive_alloc();
         #1;
         checks++; if (alloc_tag !== (TW)'(i)) begin errors++; $display("[TB] FAIL fill_tag got %0d want %0d", alloc_tag, i); end
         checks++; if (count !== (TW+1)'(i)) begin errors++; $display("[TB] FAIL fill_count got %0d want %0d", count, i); end
         tick();
      end
      drive_alloc();
      #1;
      checks++; if (full !== 1'b1) begin errors++; $display("[TB] FAIL fill_full got %b want 1", full); end
      checks++; if (alloc_ready !== 1'b0) begin errors++; $display("[TB] FAIL fill_alloc_ready got %b want 0", alloc_ready); end
      checks++; if (count !== 3'd4) begin errors++; $display("[TB] FAIL fill_count4 got %0d want 4", count); end
      tick();
      idle();
      #1;
      checks++; if (count !== 3'd4) begin errors++; $display("[TB] FAIL fill_overflow_count got %0d want 4", count); end
   endtask

   task automatic test_out_of_order_wb();
      wb_valid = 1'b1; wb_tag = 2'd2; wb_value = 32'h2222_2222;
      #1;
      checks++; if (commit_valid !== 1'b0) begin errors++; $display("[TB] FAIL ooo_wb2_cv got %b want 0", commit_valid); end
      tick();
      idle();
      #1;
      checks++; if (commit_valid !== 1'b0) begin errors++; $display("[TB] FAIL ooo_after_wb2_cv got %b want 0", commit_valid); end
      wb_valid = 1'b1; wb_tag = 2'd0; wb_value = 32'h1010_1010;
      tick();
      idle();
      #1;
      checks++; if (commit_valid !== 1'b1 || commit_tag !== 2'd0) begin errors++; $display("[TB] FAIL ooo_head0 got cv=%b tag=%0d want cv=1 tag=0", commit_valid, commit_tag); end
      checks++; if (commit_value !== 32'h1010_1010) begin errors++; $display("[TB] FAIL ooo_value0 got %h want 10101010", commit_value); end
      commit_ready = 1'b1;
      tick();
      #1;
      checks++; if (commit_valid !== 1'b0) begin errors++; $display("[TB] FAIL ooo_head1_blocked got %b want 0", commit_valid); end
      checks++; if (count !== 3'd3) begin errors++; $display("[TB] FAIL ooo_count3 got %0d want 3", count); end
      tick();
      idle();
      wb_valid = 1'b1; wb_tag = 2'd1; wb_value = 32'h1111_1111;
      tick();
      idle();
      commit_ready = 1'b1;
      #1;
      checks++; if (commit_valid !== 1'b1 || commit_tag !== 2'd1 || commit_value !== 32'h1111_1111) begin errors++; $display("[TB] FAIL ooo_head1 got cv=%b tag=%0d val=%h want cv=1 tag=1 val=11111111", commit_valid, commit_tag, commit_value); end
      tick();
      #1;
      checks++; if (commit_valid !== 1'b1 || commit_tag !== 2'd2 || commit_value !== 32'h2222_2222) begin errors++; $display("[TB] FAIL ooo_head2 got cv=%b tag=%0d val=%h want cv=1 tag=2 val=22222222", commit_valid, commit_tag, commit_value); end
      tick();
      #1;
      checks++; if (commit_valid !== 1'b0 || count !== 3'd1) begin errors++; $display("[TB] FAIL ooo_tail got cv=%b count=%0d want cv=0 count=1", commit_valid, count); end
      idle();
   endtask

   task automatic test_wrap();
      do_reset();
      for (int r = 0; r < 6; r++) begin
         drive_alloc();
         #1;
         checks++; if (alloc_tag !== (TW)'(r % 4) || empty !== 1'b1 || full !== 1'b0) begin errors++; $display("[TB] FAIL wrap_alloc round=%0d got tag=%0d empty=%b full=%b want tag=%0d empty=1 full=0", r, alloc_tag, empty, full, r % 4); end
         tick();
         idle();
         wb_valid = 1'b1; wb_tag = (TW)'(r % 4); wb_value = 32'(r * 3 + 7);
         tick();
         idle();
         commit_ready = 1'b1;
         #1;
         checks++; if (commit_valid !== 1'b1 || commit_tag !== (TW)'(r % 4) || count !== 3'd1 || commit_value !== 32'(r * 3 + 7)) begin errors++; $display("[TB] FAIL wrap_commit round=%0d got cv=%b tag=%0d count=%0d val=%0d want cv=1 tag=%0d count=1 val=%0d", r, commit_valid, commit_tag, count, commit_value, r % 4, r * 3 + 7); end
         tick();
         idle();
         #1;
         checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("[TB] FAIL wrap_empty round=%0d got empty=%b full=%b want empty=1 full=0", r, empty, full); end
      end
   endtask

   task automatic test_flush();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         drive_alloc();
         tick();
      end
      idle();
      wb_valid = 1'b1; wb_tag = 2'd0; wb_value = 32'hA0A0_A0A0;
      tick();
      idle();
      commit_ready = 1'b1;
      tick();
      idle();
      #1;
      checks++; if (count !== 3'd3) begin errors++; $display("[TB] FAIL flush_pre_count got %0d want 3", count); end
      flush_valid = 1'b1; flush_tag = 2'd1;
      drive_alloc();
      #1;
      checks++; if (alloc_ready !== 1'b0) begin errors++; $display("[TB] FAIL flush_alloc_ready got %b want 0", alloc_ready); end
      tick();
      idle();
      #1;
      checks++; if (count !== 3'd1 || alloc_tag !== 2'd2) begin errors++; $display("[TB] FAIL flush_result got count=%0d tag=%0d want count=1 tag=2", count, alloc_tag); end
      flush_valid = 1'b1; flush_tag = 2'd3;
      tick();
      idle();
      #1;
      checks++; if (count !== 3'd1) begin errors++; $display("[TB] FAIL flush_unoccupied got count=%0d want 1", count); end
      wb_valid = 1'b1; wb_tag = 2'd3; wb_value = 32'h3333_3333;
      tick();
      idle();
      #1;
      checks++; if (count !== 3'd1 || commit_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_wb_ignored got count=%0d cv=%b want count=1 cv=0", count, commit_valid); end
      wb_valid = 1'b1; wb_tag = 2'd1; wb_value = 32'h0101_0101;
      tick();
      idle();
      commit_ready = 1'b1;
      #1;
      checks++; if (commit_valid !== 1'b1 || commit_tag !== 2'd1) begin errors++; $display("[TB] FAIL flush_survivor got cv=%b tag=%0d want cv=1 tag=1", commit_valid, commit_tag); end
      tick();
      idle();
      #1;
      checks++; if (empty !== 1'b1 || alloc_tag !== 2'd2) begin errors++; $display("[TB] FAIL flush_drain got empty=%b tag=%0d want empty=1 tag=2", empty, alloc_tag); end
   endtask

   task automatic test_bypass();
      do_reset();
      drive_alloc();
      tick();
      idle();
      wb_valid = 1'b1; wb_tag = 2'd0; wb_value = 32'hDEAD_BEEF;
      #1;
      checks++; if (commit_valid !== BYPASS || (commit_valid === 1'b1 && commit_value !== 32'hDEAD_BEEF)) begin errors++; $display("[TB] FAIL bypass_same_cycle got cv=%b val=%h want cv=%b val=deadbeef", commit_valid, commit_value, BYPASS); end
      tick();
      idle();
      #1;
      checks++; if (commit_valid !== 1'b1 || commit_value !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL bypass_next_cycle got cv=%b val=%h want cv=1 val=deadbeef", commit_valid, commit_value); end
      commit_ready = 1'b1;
      tick();
      idle();
      #1;
      checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL bypass_retired got empty=%b want 1", empty); end
   endtask

   task automatic test_flush_commit();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         drive_alloc();
         tick();
      end
      idle();
      wb_valid = 1'b1; wb_tag = 2'd0; wb_value = 32'h0000_0AAA;
      tick();
      wb_tag = 2'd1; wb_value = 32'h0000_0BBB;
      tick();
      idle();
      flush_valid = 1'b1; flush_tag = 2'd1; commit_ready = 1'b1;
      #1;
      checks++; if (commit_valid !== 1'b1 || commit_tag !== 2'd0) begin errors++; $display("[TB] FAIL fc_head got cv=%b tag=%0d want cv=1 tag=0", commit_valid, commit_tag); end
      tick();
      idle();
      #1;
      checks++; if (count !== 3'd1 || alloc_tag !== 2'd2) begin errors++; $display("[TB] FAIL fc_result got count=%0d tag=%0d want count=1 tag=2", count, alloc_tag); end
      checks++; if (commit_valid !== 1'b1 || commit_tag !== 2'd1 || commit_value !== 32'h0000_0BBB) begin errors++; $display("[TB] FAIL fc_next_head got cv=%b tag=%0d val=%h want cv=1 tag=1 val=00000bbb", commit_valid, commit_tag, commit_value); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         drive_alloc();
         tick();
      end
      idle();
      wb_valid = 1'b1; wb_tag = 2'd0; wb_value = 32'h5555_5555;
      tick();
      idle();
      rst = 1'b1;
      drive_alloc();
      wb_valid = 1'b1; wb_tag = 2'd1; wb_value = 32'h6666_6666;
      commit_ready = 1'b1;
      tick();
      rst = 1'b0;
      idle();
      #1;
      checks++; if (empty !== 1'b1 || count !== 3'd0) begin errors++; $display("[TB] FAIL midreset_occ got empty=%b count=%0d want empty=1 count=0", empty, count); end
      checks++; if (commit_valid !== 1'b0 || alloc_tag !== 2'd0) begin errors++; $display("[TB] FAIL midreset_ptr got cv=%b tag=%0d want cv=0 tag=0", commit_valid, alloc_tag); end
   endtask

   task automatic test_random();
      int n;
      do_reset();
      for (int c = 0; c < 500; c++) begin
         if ($urandom_range(0, 9) < 6) drive_alloc(); else alloc_valid = 1'b0;
         wb_valid     = 1'($urandom_range(0, 1));
         wb_tag       = (TW)'($urandom_range(0, DEPTH - 1));
         wb_value     = $urandom;
         commit_ready = ($urandom_range(0, 9) < 7);
         flush_valid  = ($urandom_range(0, 19) == 0);
         flush_tag    = (TW)'($urandom_range(0, DEPTH - 1));
         #1;
         n = mq.size();
         checks++; if (count !== (TW+1)'(n) || empty !== (n == 0) || full !== (n == DEPTH)) begin errors++; $display("[TB] FAIL rand_occ cyc=%0d got count=%0d empty=%b full=%b want count=%0d", c, count, empty, full, n); end
         checks++; if (alloc_ready !== ((n != DEPTH) && !flush_valid) || alloc_tag !== (TW)'((mhead + n) % DEPTH)) begin errors++; $display("[TB] FAIL rand_alloc cyc=%0d got ready=%b tag=%0d want tag=%0d", c, alloc_ready, alloc_tag, (mhead + n) % DEPTH); end
         checks++; if (commit_valid !== m_cv()) begin errors++; $display("[TB] FAIL rand_cv cyc=%0d got %b want %b", c, commit_valid, m_cv()); end
         if (m_cv()) begin
            checks++; if (commit_tag !== (TW)'(mhead) || commit_inst_type !== mq[0].itype || commit_preg !== mq[0].preg || commit_lreg !== mq[0].lreg) begin errors++; $display("[TB] FAIL rand_head cyc=%0d got tag=%0d type=%0d preg=%0d lreg=%0d want tag=%0d type=%0d preg=%0d lreg=%0d", c, commit_tag, commit_inst_type, commit_preg, commit_lreg, mhead, mq[0].itype, mq[0].preg, mq[0].lreg); end
            checks++; if (commit_value !== m_cval()) begin errors++; $display("[TB] FAIL rand_value cyc=%0d got %h want %h", c, commit_value, m_cval()); end
         end
         tick();
      end
      idle();
   endtask

   // Scenario sequence
   initial begin
      rst             = 1'b1;
      alloc_inst_type = '0;
      alloc_preg      = '0;
      alloc_lreg      = '0;
      wb_tag          = '0;
      wb_value        = '0;
      flush_tag       = '0;
      idle();
      test_reset();
      test_fill();
      test_out_of_order_wb();
      test_wrap();
      test_flush();
      test_bypass();
      test_flush_commit();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
